// File: rtl/kanagawa_hal_pipeline_receive_fifo.sv
// kanagawa_hal_pipeline_receive_fifo: show-ahead receive FIFO absorbing in-flight writes after almost_full
module kanagawa_hal_pipeline_receive_fifo #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ROUND_TRIP = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          rd_valid,
  output logic [WIDTH-1:0]              rd_data,
  input  logic                          rd_ready,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (ROUND_TRIP >= FIFO_DEPTH) begin : g_bad_rt_hi
    $error("ROUND_TRIP must be less than FIFO_DEPTH");
  end
  if (ROUND_TRIP < 1) begin : g_bad_rt_lo
    $error("ROUND_TRIP must be at least 1");
  end
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d, ov_q, ov_d;
  logic          rd_fire, wr_acc;
  always_comb begin
    rd_fire  = (count_q != '0) && rd_ready;
    wr_acc   = wr_valid && ((count_q != CW'(FIFO_DEPTH)) || rd_fire);
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_fire);
    af_d     = count_d >= CW'(FIFO_DEPTH - ROUND_TRIP);
    ov_d     = ov_q || (wr_valid && !wr_acc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ov_q     <= ov_d;
    end
  end
  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end
  assign rd_valid    = count_q != '0;
  assign rd_data     = mem[rd_ptr_q];
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = ov_q;
endmodule

// File: tb/tb_kanagawa_hal_pipeline_receive_fifo.sv
// tb_kanagawa_hal_pipeline_receive_fifo: table, directed and random checks against a queue model
module tb_kanagawa_hal_pipeline_receive_fifo;
  localparam int W = 8, D = 8, RT = 3;
  logic clk = 0, rst_n = 0, wr_valid = 0, rd_ready = 0;
  logic [W-1:0] wr_data = '0, rd_data;
  logic rd_valid, almost_full, overflow;
  logic [3:0] count;
  int passed = 0, total = 0;
  logic [W-1:0] mq[$];
  bit m_af, m_ov;
  typedef struct {
    bit wv; logic [W-1:0] wd; bit rr;
    int cnt; bit vld; logic [W-1:0] dat; bit af; bit ov;
  } vec_t;
  vec_t tbl[12];
  kanagawa_hal_pipeline_receive_fifo #(.WIDTH(W), .FIFO_DEPTH(D), .ROUND_TRIP(RT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .almost_full(almost_full), .count(count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask
  task automatic cmp_model();
    chk("count", count, mq.size());
    chk("rd_valid", rd_valid, mq.size() != 0);
    chk("almost_full", almost_full, m_af);
    chk("overflow", overflow, m_ov);
    if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
  endtask
  task automatic model_clear();
    mq.delete();
    m_af = 0;
    m_ov = 0;
  endtask
  // Inputs change at negedge, model advances at posedge, outputs compared at next negedge.
  task automatic cycle(input bit wv, input logic [W-1:0] wd, input bit rr);
    bit rf, acc;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    @(posedge clk);
    rf  = (mq.size() != 0) && rr;
    acc = wv && (mq.size() < D || rf);
    if (rf) void'(mq.pop_front());
    if (acc) mq.push_back(wd);
    if (wv && !acc) m_ov = 1;
    m_af = mq.size() >= D - RT;
    @(negedge clk);
    cmp_model();
  endtask
  task automatic do_reset();
    wr_valid = 0; rd_ready = 0; rst_n = 0;
    model_clear();
    repeat (2) @(negedge clk);
    cmp_model();
    rst_n = 1;
  endtask
  initial begin
    tbl[0]  = '{1, 8'hA1, 0, 1, 1, 8'hA1, 0, 0};
    tbl[1]  = '{1, 8'hA2, 0, 2, 1, 8'hA1, 0, 0};
    tbl[2]  = '{1, 8'hA3, 0, 3, 1, 8'hA1, 0, 0};
    tbl[3]  = '{0, 8'h00, 1, 2, 1, 8'hA2, 0, 0};
    tbl[4]  = '{0, 8'h00, 1, 1, 1, 8'hA3, 0, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0};
    tbl[6]  = '{1, 8'hB1, 0, 1, 1, 8'hB1, 0, 0};
    tbl[7]  = '{1, 8'hB2, 0, 2, 1, 8'hB1, 0, 0};
    tbl[8]  = '{1, 8'hB3, 0, 3, 1, 8'hB1, 0, 0};
    tbl[9]  = '{1, 8'hB4, 0, 4, 1, 8'hB1, 1'b0, 0};
    tbl[10] = '{1, 8'hB5, 0, 5, 1, 8'hB1, 1, 0};
    tbl[11] = '{0, 8'h00, 1, 4, 1, 8'hB2, 0, 0};
    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].wv, tbl[i].wd, tbl[i].rr);
      chk($sformatf("tbl%0d count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d valid", i), rd_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl%0d data", i), rd_data, tbl[i].dat);
      chk($sformatf("tbl%0d af", i), almost_full, tbl[i].af);
      chk($sformatf("tbl%0d ov", i), overflow, tbl[i].ov);
    end
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, 8'hC0 + 8'(i), 0);
    chk("ovf count", count, 8);
    chk("ovf flag", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf drain data", rd_data, 8'hC0 + i);
      cycle(0, 0, 1);
    end
    chk("ovf sticky", overflow, 1);
    chk("ovf empty", rd_valid, 0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 8'hD0 + 8'(i), 0);
    cycle(1, 8'h55, 1);
    chk("full simul count", count, 8);
    chk("full simul ov", overflow, 0);
    chk("full simul head", rd_data, 8'hD1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(1, 8'(i + 1), 1);
      chk("wrap data", rd_data, i + 1);
      chk("wrap count", count, 1);
    end
    cycle(0, 0, 1);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 8'hE0 + 8'(i), 0);
    chk("pre-reset af", almost_full, 1);
    #2 rst_n = 0;
    #1;
    model_clear();
    chk("async count", count, 0);
    chk("async valid", rd_valid, 0);
    chk("async af", almost_full, 0);
    chk("async ov", overflow, 0);
    @(negedge clk);
    rst_n = 1;
    cycle(1, 8'h77, 0);
    chk("post-reset data", rd_data, 8'h77);
    cycle(0, 0, 1);
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int wp = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
      int rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 90;
      for (int i = 0; i < 60; i++)
        cycle($urandom_range(99) < wp, W'($urandom), $urandom_range(99) < rp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/kanagawa_hal_pipeline_receive_fifo.md
Name: kanagawa_hal_pipeline_receive_fifo

Overview:
- Receive end of a fixed-latency, non-backpressured register pipeline built from non-mergeable register stages.
- Upstream issues writes only while it sees almost_full low. almost_full travels back through ROUND_TRIP cycles of registers, so this block must absorb every in-flight write after asserting it.
- Provides a show-ahead ready/valid read port, occupancy count, and a sticky overflow flag for protocol-violation detection.

Parameters:
- WIDTH, 32, data width in bits; must be at least 1.
- FIFO_DEPTH, 16, number of entries; power of two, at least 2.
- ROUND_TRIP, 4, worst-case cycles from almost_full assertion to the last in-flight write arriving; 1 <= ROUND_TRIP < FIFO_DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- wr_valid  in  1  write strobe from the pipeline tail; no backpressure.
- wr_data  in  WIDTH  write data, qualified by wr_valid.
- rd_valid  out  1  head entry is valid.
- rd_data  out  WIDTH  head entry data; undefined when rd_valid is 0.
- rd_ready  in  1  consumer accepts the head entry; a read fires when rd_valid and rd_ready are both 1.
- almost_full  out  1  registered flow-control flag returned to the producer.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0 to FIFO_DEPTH.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count, write pointer and read pointer go to 0.
  - almost_full, overflow and rd_valid go to 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents. In-flight writes arriving after release are accepted normally.
- Storage:
  - FIFO_DEPTH x WIDTH register array.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- Write acceptance:
  - A write is accepted when wr_valid is 1 and either count < FIFO_DEPTH or a read fires in the same cycle.
  - An accepted write stores wr_data at the write pointer and increments the pointer.
  - When count == FIFO_DEPTH, a write without a simultaneous read is dropped. No state changes except overflow, which goes to 1 on the next edge and stays 1 until reset.
- Read:
  - Show-ahead: rd_valid = (count != 0), and rd_data is read combinationally from the array at the read pointer.
  - A read fire increments the read pointer.
- No bypass: a write into an empty FIFO appears on rd_valid/rd_data in the following cycle (write-to-read latency 1).
- count update: count_next = count + accepted_write - read_fire. A simultaneous write and read leaves count unchanged, at any occupancy.
- almost_full:
  - Register loaded every cycle with (count_next >= FIFO_DEPTH - ROUND_TRIP).
  - It therefore rises in the cycle after the write that reaches the threshold, and falls in the cycle after occupancy drops below it.
- Guarantee: a producer obeying almost_full with latency <= ROUND_TRIP never causes overflow.
- Elaboration checks (simulation only, same style as other HAL mocks): error if FIFO_DEPTH is not a power of two, if ROUND_TRIP >= FIFO_DEPTH, or if ROUND_TRIP < 1.
- Simulation checks: rd_ready while rd_valid is 0 is legal and ignored.

Test Plan:
- FIFO_DEPTH=8, ROUND_TRIP=3: write 0xA1, 0xA2, 0xA3 on consecutive cycles with rd_ready=0 -> rd_valid rises 1 cycle after the first write, count=3. Then rd_ready=1 for 3 cycles -> reads 0xA1, 0xA2, 0xA3 in order, count=0, rd_valid=0.
- Threshold: write 5 entries with no reads -> almost_full goes to 1 the cycle after the 5th write. Read 1 entry -> almost_full goes to 0 one cycle later, count=4.
- Overflow: write 9 entries with no reads -> first 8 stored, count=8, 9th dropped, overflow=1 and sticky. Drain -> 8 original values in order, overflow still 1.
- Full simultaneous: count=8, wr_valid=1 with data 0x55 and rd_ready=1 -> head popped, 0x55 stored, count stays 8, overflow stays 0.
- Wrap-around: stream 40 sequential values with rd_ready=1 every cycle -> all received in order with 1-cycle latency, count never exceeds 1, pointers wrap 5 times.
- Reset mid-operation: count=6, assert rst_n=0 asynchronously between edges -> count, rd_valid, almost_full and overflow go to 0 immediately. After release, write 0x77 -> read returns 0x77.
